// File: rtl/jtframe_ddram_resp.sv
// rtl/jtframe_ddram_resp.sv - Avalon-MM burst responder for the ddram_* port, backed by block RAM
module jtframe_ddram_resp #(
    parameter int AW      = 10,
    parameter int LATENCY = 4,
    parameter int STALL   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ddram_busy,
    input  logic [7:0]  ddram_burstcnt,
    input  logic [28:0] ddram_addr,
    output logic [63:0] ddram_dout,
    output logic        ddram_dout_ready,
    input  logic        ddram_rd,
    input  logic [63:0] ddram_din,
    input  logic [7:0]  ddram_be,
    input  logic        ddram_we,
    input  logic [7:0]  st_addr,
    output logic [7:0]  st_dout
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_WAIT = 3'd2,
        S_READ    = 3'd3,
        S_STALL   = 3'd4
    } state_t;

    localparam logic [3:0]  WAIT_INIT  = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    localparam logic [15:0] STALL_LAST = 16'(STALL > 0 ? STALL - 1 : 0);

    state_t          state, state_n;
    logic            in_reset;
    logic            ret_write;
    logic [AW-1:0]   cur_addr;
    logic [7:0]      rem;
    logic [3:0]      wait_cnt;
    logic [15:0]     beat_cnt;
    logic [7:0]      rd_bursts, wr_bursts, err_cnt;

    logic            wr_beat, wr_first, wr_last, rd_accept, stall_hit;
    logic [1:0]      err_inc;
    logic [8:0]      err_sum;
    logic [AW-1:0]   wr_addr;
    logic [7:0]      cnt_eff;

    logic [63:0]     mem [2**AW];

    logic unused;
    assign unused = &{1'b0, ddram_addr[28:AW]};

    // The last read beat still holds busy so no command lands while it is on the bus
    assign ddram_busy = in_reset | ddram_dout_ready | (state == S_RD_WAIT) |
                        (state == S_READ) | (state == S_STALL);

    always_comb begin
        state_n   = state;
        wr_beat   = 1'b0;
        wr_first  = 1'b0;
        wr_last   = 1'b0;
        rd_accept = 1'b0;
        stall_hit = 1'b0;
        err_inc   = 2'd0;
        wr_addr   = cur_addr;
        cnt_eff   = (ddram_burstcnt == 8'd0) ? 8'd1 : ddram_burstcnt;
        case (state)
            S_IDLE: begin
                if (!ddram_busy) begin
                    if (ddram_we) begin
                        wr_beat  = 1'b1;
                        wr_first = 1'b1;
                        wr_addr  = ddram_addr[AW-1:0];
                        wr_last  = (cnt_eff == 8'd1);
                        err_inc  = 2'(ddram_rd) + 2'(ddram_burstcnt == 8'd0);
                    end else if (ddram_rd) begin
                        rd_accept = 1'b1;
                        err_inc   = 2'(ddram_burstcnt == 8'd0);
                        state_n   = (LATENCY > 1) ? S_RD_WAIT : S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (ddram_we) begin
                    wr_beat = 1'b1;
                    wr_last = (rem == 8'd1);
                end
                if (ddram_rd) err_inc = 2'd1;
            end
            S_RD_WAIT: if (wait_cnt == 4'd0) state_n = S_READ;
            S_READ:    if (rem == 8'd1) state_n = S_IDLE;
            S_STALL:   state_n = ret_write ? S_WRITE : S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        if (wr_beat) begin
            stall_hit = (STALL != 0) && (beat_cnt == STALL_LAST);
            state_n   = stall_hit ? S_STALL : (wr_last ? S_IDLE : S_WRITE);
        end
        err_sum = {1'b0, err_cnt} + {7'd0, err_inc};
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_beat) begin
            for (int i = 0; i < 8; i++) begin
                if (ddram_be[i]) mem[wr_addr][8*i +: 8] <= ddram_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            in_reset         <= 1'b1;
            ret_write        <= 1'b0;
            cur_addr         <= '0;
            rem              <= 8'd0;
            wait_cnt         <= 4'd0;
            beat_cnt         <= 16'd0;
            rd_bursts        <= 8'd0;
            wr_bursts        <= 8'd0;
            err_cnt          <= 8'd0;
            ddram_dout       <= 64'd0;
            ddram_dout_ready <= 1'b0;
            st_dout          <= 8'd0;
        end else begin
            state            <= state_n;
            in_reset         <= 1'b0;
            ddram_dout_ready <= (state == S_READ);
            if (state == S_READ) begin
                ddram_dout <= mem[cur_addr];
                cur_addr   <= cur_addr + 1'b1;
                rem        <= rem - 8'd1;
                if (rem == 8'd1) rd_bursts <= rd_bursts + 8'd1;
            end
            if (state == S_RD_WAIT) wait_cnt <= wait_cnt - 4'd1;
            if (rd_accept) begin
                cur_addr <= ddram_addr[AW-1:0];
                rem      <= cnt_eff;
                wait_cnt <= WAIT_INIT;
            end
            if (wr_beat) begin
                cur_addr <= wr_addr + 1'b1;
                rem      <= wr_first ? cnt_eff - 8'd1 : rem - 8'd1;
                beat_cnt <= stall_hit ? 16'd0 : beat_cnt + 16'd1;
                if (wr_last) wr_bursts <= wr_bursts + 8'd1;
            end
            if (stall_hit) ret_write <= !wr_last;
            err_cnt <= err_sum[8] ? 8'd255 : err_sum[7:0];
            case (st_addr)
                8'd0:    st_dout <= rd_bursts;
                8'd1:    st_dout <= wr_bursts;
                8'd2:    st_dout <= err_cnt;
                8'd3:    st_dout <= {5'd0, state};
                default: st_dout <= 8'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_ddram_resp.sv
// tb/tb_jtframe_ddram_resp.sv - testbench for jtframe_ddram_resp
module tb_jtframe_ddram_resp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        we, rd;
    logic [28:0] addr;
    logic [7:0]  burstcnt, be, st_addr;
    logic [63:0] din;
    logic        we_a, we_b, rd_a, rd_b;
    logic        busy_a, busy_b, rdy_a, rdy_b;
    logic [63:0] dout_a, dout_b;
    logic [7:0]  st_a, st_b;
    logic        busy_cur, rdy_cur;
    logic [63:0] dout_cur;
    logic [7:0]  st_cur;

    int          checks = 0;
    int          errors = 0;
    bit          reading;
    logic [63:0] mem_a [1024];
    logic [63:0] mem_b [1024];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    assign we_a     = we & ~sel;
    assign we_b     = we & sel;
    assign rd_a     = rd & ~sel;
    assign rd_b     = rd & sel;
    assign busy_cur = sel ? busy_b : busy_a;
    assign rdy_cur  = sel ? rdy_b : rdy_a;
    assign dout_cur = sel ? dout_b : dout_a;
    assign st_cur   = sel ? st_b : st_a;

    jtframe_ddram_resp #(.AW(10), .LATENCY(4), .STALL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ddram_busy(busy_a), .ddram_burstcnt(burstcnt),
        .ddram_addr(addr), .ddram_dout(dout_a), .ddram_dout_ready(rdy_a), .ddram_rd(rd_a),
        .ddram_din(din), .ddram_be(be), .ddram_we(we_a), .st_addr(st_addr), .st_dout(st_a)
    );

    jtframe_ddram_resp #(.AW(10), .LATENCY(4), .STALL(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ddram_busy(busy_b), .ddram_burstcnt(burstcnt),
        .ddram_addr(addr), .ddram_dout(dout_b), .ddram_dout_ready(rdy_b), .ddram_rd(rd_b),
        .ddram_din(din), .ddram_be(be), .ddram_we(we_b), .st_addr(st_addr), .st_dout(st_b)
    );

    typedef struct {
        bit          inst;
        bit          is_rd;
        bit          with_rd;
        logic [28:0] a;
        logic [7:0]  cnt;
        logic [7:0]  m;
        logic [63:0] d0;
        int          exp_cyc;
        logic [15:0] exp_mask;
    } op_t;

    typedef struct {
        bit          inst;
        logic [7:0]  sa;
        logic [7:0]  exp;
    } st_t;

    op_t ops [10];
    st_t sts [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_wr(input bit inst, input int a, input logic [63:0] d, input logic [7:0] m);
        logic [63:0] w;
        w = inst ? mem_b[a] : mem_a[a];
        for (int i = 0; i < 8; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
        if (inst) mem_b[a] = w;
        else      mem_a[a] = w;
    endtask

    task automatic wr_burst(input bit inst, input bit with_rd, input logic [28:0] a,
                            input logic [7:0] cnt, input logic [7:0] m, input logic [63:0] d0,
                            input int exp_cyc, input logic [15:0] exp_mask, input string name);
        int          n, beat, cyc;
        logic [15:0] mask;
        logic [63:0] d;
        bit          acc;
        n = (cnt == 8'd0) ? 1 : int'(cnt);
        beat = 0; cyc = 0; mask = 16'd0;
        sel = inst; addr = a; burstcnt = cnt; be = m;
        while (beat < n && cyc < 64) begin
            d   = d0 * 64'(beat + 1);
            din = d; we = 1'b1; rd = with_rd && (beat == 0);
            acc = !busy_cur;
            if (!acc && cyc < 16) mask[cyc] = 1'b1;
            @(negedge clk);
            if (acc) begin
                model_wr(inst, (int'(a[9:0]) + beat) % 1024, d, m);
                beat++;
            end
            cyc++;
        end
        we = 1'b0; rd = 1'b0;
        chk({name, " cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({name, " busy pattern"}, 64'(mask), 64'(exp_mask));
    endtask

    task automatic rd_burst(input bit inst, input logic [28:0] a, input logic [7:0] cnt,
                            input string name);
        int n, w, lat;
        n = (cnt == 8'd0) ? 1 : int'(cnt);
        sel = inst; addr = a; burstcnt = cnt; rd = 1'b1; we = 1'b0;
        w = 0;
        while (busy_cur && w < 64) begin @(negedge clk); w++; end
        chk({name, " accept"}, 64'(w < 64), 64'd1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(inst ? mem_b[(int'(a[9:0]) + i) % 1024] : mem_a[(int'(a[9:0]) + i) % 1024]);
        end
        reading = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        lat = 0;
        while (!rdy_cur && lat < 40) begin @(negedge clk); lat++; end
        chk({name, " latency"}, 64'(lat), 64'd4);
        for (int i = 0; i < n; i++) begin
            chk({name, " ready"}, 64'(rdy_cur), 64'd1);
            if (exp_q.size() > 0) chk({name, " data"}, dout_cur, exp_q.pop_front());
            else chk({name, " scoreboard empty"}, 64'd1, 64'd0);
            @(negedge clk);
        end
        reading = 1'b0;
        chk({name, " ready after"}, 64'(rdy_cur), 64'd0);
        chk({name, " busy after"}, 64'(busy_cur), 64'd0);
    endtask

    task automatic st_chk(input bit inst, input logic [7:0] sa, input logic [7:0] exp, input string name);
        sel = inst; st_addr = sa;
        @(negedge clk);
        chk(name, 64'(st_cur), 64'(exp));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && !reading && (rdy_a || rdy_b)) begin
            errors++;
            $display("FAIL stray dout_ready: got 1 expected 0");
        end
    end

    initial begin
        int  w;
        bit  seen;
        sel = 1'b0; we = 1'b0; rd = 1'b0; addr = '0; burstcnt = 8'd0; be = 8'd0;
        din = 64'd0; st_addr = 8'd0; rst_n = 1'b0; reading = 1'b0;

        ops[0] = '{0, 0, 0, 29'h10,        8'd4, 8'hFF, 64'h1111,                4, 16'h0};
        ops[1] = '{0, 1, 0, 29'h10,        8'd4, 8'hFF, 64'h0,                   0, 16'h0};
        ops[2] = '{0, 0, 0, 29'h3FF,       8'd2, 8'hFF, 64'h0123_4567_89AB_CDEF, 2, 16'h0};
        ops[3] = '{0, 0, 0, 29'h0ABC_03FF, 8'd2, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 2, 16'h0};
        ops[4] = '{0, 1, 0, 29'h3FF,       8'd2, 8'hFF, 64'h0,                   0, 16'h0};
        ops[5] = '{1, 0, 0, 29'h20,        8'd5, 8'hFF, 64'h0101_0101_0101_0101, 7, 16'h0024};
        ops[6] = '{1, 1, 0, 29'h20,        8'd5, 8'hFF, 64'h0,                   0, 16'h0};
        ops[7] = '{0, 0, 1, 29'h40,        8'd1, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1, 16'h0};
        ops[8] = '{0, 0, 0, 29'h41,        8'd0, 8'hFF, 64'h0BAD_F00D_0000_0002, 1, 16'h0};
        ops[9] = '{0, 1, 0, 29'h40,        8'd2, 8'hFF, 64'h0,                   0, 16'h0};

        sts[0] = '{0, 8'd0, 8'd3};
        sts[1] = '{0, 8'd1, 8'd5};
        sts[2] = '{0, 8'd2, 8'd2};
        sts[3] = '{0, 8'd3, 8'd0};
        sts[4] = '{0, 8'd7, 8'd0};
        sts[5] = '{1, 8'd0, 8'd1};
        sts[6] = '{1, 8'd1, 8'd1};
        sts[7] = '{1, 8'd2, 8'd0};

        @(negedge clk);
        chk("reset busy a", 64'(busy_a), 64'd1);
        chk("reset busy b", 64'(busy_b), 64'd1);
        chk("reset ready", 64'(rdy_a), 64'd0);
        chk("reset dout", dout_a, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("busy after reset a", 64'(busy_a), 64'd0);
        chk("busy after reset b", 64'(busy_b), 64'd0);
        for (int i = 0; i < 3; i++) st_chk(0, 8'(i), 8'd0, "reset status");

        for (int i = 0; i < 10; i++) begin
            if (ops[i].is_rd) rd_burst(ops[i].inst, ops[i].a, ops[i].cnt, $sformatf("op%0d rd", i));
            else wr_burst(ops[i].inst, ops[i].with_rd, ops[i].a, ops[i].cnt, ops[i].m, ops[i].d0,
                          ops[i].exp_cyc, ops[i].exp_mask, $sformatf("op%0d wr", i));
        end

        for (int i = 0; i < 8; i++) st_chk(sts[i].inst, sts[i].sa, sts[i].exp, $sformatf("status%0d", i));

        sel = 1'b0; addr = 29'h10; burstcnt = 8'd8; rd = 1'b1; reading = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        w = 0;
        while (!rdy_a && w < 40) begin @(negedge clk); w++; end
        chk("mid-read beat1", dout_a, mem_a[16]);
        @(negedge clk);
        chk("mid-read beat2 ready", 64'(rdy_a), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid-read reset busy", 64'(busy_a), 64'd1);
        chk("mid-read reset ready", 64'(rdy_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; reading = 1'b0;
        @(negedge clk);
        chk("post reset busy", 64'(busy_a), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            if (rdy_a) seen = 1'b1;
            @(negedge clk);
        end
        chk("no ready after reset", 64'(seen), 64'd0);
        st_chk(0, 8'd2, 8'd0, "errors cleared");
        st_chk(0, 8'd0, 8'd0, "reads cleared");

        wr_burst(0, 0, 29'h80, 8'd2, 8'hFF, 64'h7777_0000_0000_0007, 2, 16'h0, "post-reset wr");
        rd_burst(0, 29'h80, 8'd2, "post-reset rd");
        st_chk(0, 8'd1, 8'd1, "post-reset writes");
        st_chk(0, 8'd0, 8'd1, "post-reset reads");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
